uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Buffered 8N1 UART transmitter driving the board `txd` pin. It sits directly downstream of the top-level I/O controller and the core's output path. It accepts one-shot handshake bytes (program/data request signals) and a stream of core output bytes, queues them in a small FIFO, and serialises them LSB-first. It gives the core backpressure through `stall`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; minimum 2.
- `DEPTH`, default 16: FIFO depth in bytes; power of two, minimum 2.

Ports:
- `clk`  in  1  the single clock for the block; all state is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle pulse; enqueue `sendsig` when `mode`=1.
- `mode`  in  1  1 = signal mode (`TX_MODE_SIG`), 0 = stream mode (`TX_MODE_DMA`).
- `sendsig`  in  8  handshake byte, e.g. 0x99 or 0xAA.
- `write_output`  in  1  core output byte valid.
- `output_data`  in  8  core output byte.
- `stall`  out  1  core must hold `write_output`/`output_data`; combinational.
- `txd`  out  1  serial line, idle high.
- `overflow`  out  1  sticky; a signal byte was dropped because the FIFO was full.
- `busy`  out  1  FIFO non-empty or a frame is in progress.

## Operation
- Enqueue sources, evaluated each cycle:
  - Signal push: `start & mode`.
  - Stream push: `write_output & ~mode & ~stall`.
  - Signal push has priority. `stall = full | start`, so the two sources never push in the same cycle.
  - `start` with `mode`=0 is ignored.
- Full FIFO:
  - A stream push is blocked by `stall`; the core retries.
  - A signal push is dropped and sets `overflow`. `overflow` clears only on `rst`.
- FIFO arithmetic:
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Count is `$clog2(DEPTH)+1` bits.
  - Push and pop in the same cycle leave count unchanged. This is legal when full (a pop frees a slot, but `stall` still uses the pre-edge `full`) and when empty-with-push (no pop occurs, because pop needs count≠0 pre-edge).
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: `txd`=1. If count≠0: pop the head into the shift register, `txd`←0, go to START.
  - START: hold for `CLKS_PER_BIT` cycles, then `txd`←bit0, bit index←0, go to DATA.
  - DATA: each `CLKS_PER_BIT` cycles shift out the next bit, LSB first. After bit 7's period, `txd`←1, go to STOP.
  - STOP: hold for `CLKS_PER_BIT` cycles. Then, if count≠0, pop and go to START with `txd`←0 (no idle gap). Otherwise go to IDLE.
- Bit counter counts `CLKS_PER_BIT-1` down to 0. `txd` is registered (glitch-free).

## Timing
- Reset values: `txd`=1, `overflow`=0, `busy`=0, FSM=IDLE, FIFO empty, pointers 0. `stall` = `start` during reset.
- Reset mid-frame: `txd` returns high asynchronously and queued bytes are discarded.
- Latency: byte accepted at edge N with FSM idle → `txd` falls after edge N+1.
- Frame length: exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- `stall` depends on current-cycle `start` and registered `full` only. It has no path from `write_output`.
- `busy` falls the cycle after the final stop-bit period ends with an empty FIFO.

## Structure
- Shared package `utils` gains:
  - `UART_CLKS_PER_BIT`;
  - `TX_FIFO_DEPTH`;
  - `TX_MODE_SIG`/`TX_MODE_DMA` (moved from the top level);
  - `SIG_SEND_PROG`/`SIG_SEND_DATA` (moved from the top level).
- FSM state enum `tx_state_t` is local to the module.
- One sub-module, `byte_fifo`: parameter `DEPTH`; ports `push`/`din`/`pop`/`dout`/`full`/`empty`/`count`; same async active-high reset.
- FSM, bit counter, and shift register stay in `uart_tx_queue`.

## Test plan
Benches use `CLKS_PER_BIT`=4, `DEPTH`=4.
- Signal byte: `start`=1, `mode`=1, `sendsig`=0x99, idle → `txd` low two edges later. Bits sample 1,0,0,1,1,0,0,1, then stop=1. Frame is 40 cycles; `busy` drops after.
- Stream burst: 6 consecutive `write_output` bytes 0x01..0x06 in `mode`=0, core honouring `stall`:
  - `stall` rises when 4 bytes are queued;
  - all 6 bytes appear on `txd` in order with no inter-frame gap;
  - total 240 cycles from the first start bit.
- Priority: `start`(`mode`=1, 0xAA) in the same cycle as `write_output`=0x55 → `stall`=1 and 0x55 is not accepted. With the core holding 0x55 and switching `mode` to 0 next cycle, 0xAA is sent first, then 0x55.
- Overflow: fill the FIFO (4 bytes plus 1 in flight), pulse `start` (`mode`=1) → `overflow`=1 and stays high. Only the original 5 bytes are sent.
- Wrap-around: push/pop 9 bytes in a trickle (one every 50 cycles) → pointers wrap twice and bytes 0x10..0x18 are received intact.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued → `txd`=1 immediately, `busy`=0, `overflow`=0. After release, nothing is transmitted.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared package `utils` for the UART transmit path.
// Holds the board-level UART bit timing, the transmit FIFO depth, the
// transmit source mode encodings and the handshake bytes sent to the host.
package utils;

    // Clock cycles per UART bit for the board clock.
    localparam int UART_CLKS_PER_BIT = 868;

    // Transmit FIFO depth in bytes (power of two).
    localparam int TX_FIFO_DEPTH = 16;

    // Transmit source select: one-shot handshake byte or core output stream.
    localparam logic TX_MODE_SIG = 1'b1;
    localparam logic TX_MODE_DMA = 1'b0;

    // Handshake bytes requesting program and data transfers.
    localparam logic [7:0] SIG_SEND_PROG = 8'h99;
    localparam logic [7:0] SIG_SEND_DATA = 8'hAA;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host-side handshake bundle of the UART transmit queue.
// Signals:
//   start        one-cycle pulse, enqueue sendsig when mode is signal mode
//   mode         TX_MODE_SIG / TX_MODE_DMA source select
//   sendsig      handshake byte
//   write_output core output byte valid
//   output_data  core output byte
//   stall        backpressure to the core (combinational)
// Modports: master = controller/core side, slave = transmit queue side.
interface uart_tx_queue_if;
    logic       start;
    logic       mode;
    logic [7:0] sendsig;
    logic       write_output;
    logic [7:0] output_data;
    logic       stall;

    modport master (
        output start,
        output mode,
        output sendsig,
        output write_output,
        output output_data,
        input  stall
    );

    modport slave (
        input  start,
        input  mode,
        input  sendsig,
        input  write_output,
        input  output_data,
        output stall
    );
endinterface

// File: rtl/uart_tx_queue_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO with a combinational head read.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, din     write request and data (a push while full is only taken
//                 together with a pop)
//   pop, dout     read request and current head byte
//   full, empty   occupancy flags derived from count
//   count         number of stored bytes, $clog2(DEPTH)+1 bits
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    // A full FIFO can still accept a byte when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffered 8N1 UART transmitter for the board txd pin.
// Handshake bytes (signal mode) and core output bytes (stream mode) are
// queued in a byte_fifo and serialised LSB first, back to back when queued.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   host       handshake bundle (start/mode/sendsig/write_output/output_data/stall)
//   txd        registered serial output, idle high
//   overflow   sticky flag: a signal byte was dropped on a full FIFO
//   busy       FIFO non-empty or a frame in progress
module uart_tx_queue
    import utils::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DEPTH        = TX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_queue_if.slave   host,
    output logic             txd,
    output logic             overflow,
    output logic             busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]     shift_r, shift_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic           txd_r, txd_s;
    logic           overflow_r, overflow_s;
    logic           pop_s;
    logic           sig_push_s;
    logic           dma_push_s;
    logic           push_s;
    logic [7:0]     push_data_s;
    logic           stall_s;
    logic [7:0]     fifo_dout_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [CW-1:0]  fifo_count_s;

    // The signal source wins by stalling the stream whenever start is high,
    // so at most one source pushes per cycle and stall never sees write_output.
    assign sig_push_s  = host.start & (host.mode == TX_MODE_SIG);
    assign stall_s     = fifo_full_s | host.start;
    assign dma_push_s  = host.write_output & (host.mode == TX_MODE_DMA) & ~stall_s;
    assign push_s      = (sig_push_s & ~fifo_full_s) | dma_push_s;
    assign push_data_s = sig_push_s ? host.sendsig : host.output_data;
    assign host.stall  = stall_s;

    assign txd      = txd_r;
    assign overflow = overflow_r;
    assign busy     = (state_r != IDLE) | ~fifo_empty_s;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (push_data_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Sticky overflow: a signal byte arriving on a full FIFO is lost.
    always_comb begin
        overflow_s = overflow_r;
        if (sig_push_s && fifo_full_s) begin
            overflow_s = 1'b1;
        end else begin
            overflow_s = overflow_r;
        end
    end

    // Transmit FSM next state, bit timer, shift register and next txd level.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        shift_s   = shift_r;
        bit_idx_s = bit_idx_r;
        txd_s     = txd_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                txd_s = 1'b1;
                if (fifo_count_s != CW'(0)) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_dout_s;
                    txd_s   = 1'b0;
                    cnt_s   = CNT_MAX;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_W'(0)) begin
                    txd_s     = shift_r[0];
                    bit_idx_s = 3'd0;
                    cnt_s     = CNT_MAX;
                    state_s   = DATA;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == CNT_W'(0)) begin
                    cnt_s = CNT_MAX;
                    if (bit_idx_r == 3'd7) begin
                        txd_s   = 1'b1;
                        state_s = STOP;
                    end else begin
                        // Shift so the next data bit is always at shift_r[0].
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        txd_s     = shift_r[1];
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == CNT_W'(0)) begin
                    // Start the next queued frame directly, without an idle bit.
                    if (fifo_count_s != CW'(0)) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_dout_s;
                        txd_s   = 1'b0;
                        cnt_s   = CNT_MAX;
                        state_s = START;
                    end else begin
                        txd_s   = 1'b1;
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                txd_s   = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // Transmit state registers; reset forces the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_W'(0);
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            txd_r      <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            bit_idx_r  <= bit_idx_s;
            txd_r      <= txd_s;
            overflow_r <= overflow_s;
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with CLKS_PER_BIT=4, DEPTH=4.
module tb_uart_tx_queue;
    import utils::*;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst;
    logic txd;
    logic overflow;
    logic busy;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_queue_if bus();

    uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (bus),
        .txd      (txd),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a start bit, then sample each bit at its centre.
    task automatic rx_byte(output logic [7:0] b, output int t0);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_wait_bound", 32'(n < 3000), 32'd1);
        t0 = cyc;
        repeat (2) @(negedge clk);
        chk("start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = txd;
        end
        repeat (4) @(negedge clk);
        chk("stop_bit", 32'(txd), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int t, tprev, t_first, first_stall, sent, n, lows;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode = TX_MODE_DMA;
        bus.sendsig = 8'h00;
        bus.write_output = 1'b0;
        bus.output_data = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        bus.start = 1'b1;
        #1;
        chk("rst_stall_start", 32'(bus.stall), 32'd1);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Signal byte 0x99
        bus.start = 1'b1;
        bus.mode = TX_MODE_SIG;
        bus.sendsig = SIG_SEND_PROG;
        #1;
        chk("sig_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("sig_latency_n", 32'(txd), 32'd1);
        chk("sig_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sig_latency_n1", 32'(txd), 32'd0);
        rx_byte(b, t);
        chk("sig_byte", 32'(b), 32'h99);
        @(negedge clk);
        chk("sig_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sig_busy_drop", 32'(busy), 32'd0);
        chk("sig_txd_idle", 32'(txd), 32'd1);

        // Stream burst 0x01..0x06 honouring stall
        bus.mode = TX_MODE_DMA;
        @(negedge clk);
        fork
            begin
                sent = 0;
                first_stall = -1;
                n = 0;
                while (sent < 6 && n < 500) begin
                    bus.write_output = 1'b1;
                    bus.output_data = 8'(sent + 1);
                    #1;
                    if (bus.stall) begin
                        if (first_stall < 0) first_stall = sent;
                    end else begin
                        sent++;
                    end
                    @(negedge clk);
                    n++;
                end
                bus.write_output = 1'b0;
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    rx_byte(b, t);
                    chk("burst_byte", 32'(b), 32'(j + 1));
                    if (j == 0) t_first = t;
                    else chk("burst_gap", 32'(t - tprev), 32'd40);
                    tprev = t;
                end
            end
        join
        chk("burst_first_stall", 32'(first_stall), 32'd5);
        @(negedge clk);
        chk("burst_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("burst_busy_drop", 32'(busy), 32'd0);
        chk("burst_total", 32'(cyc - t_first), 32'd240);

        // Priority: start with 0xAA beats write_output 0x55
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = TX_MODE_SIG;
        bus.sendsig = SIG_SEND_DATA;
        bus.write_output = 1'b1;
        bus.output_data = 8'h55;
        #1;
        chk("prio_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode = TX_MODE_DMA;
        #1;
        chk("prio_stall_release", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.write_output = 1'b0;
        rx_byte(b, t);
        chk("prio_first", 32'(b), 32'hAA);
        tprev = t;
        rx_byte(b, t);
        chk("prio_second", 32'(b), 32'h55);
        chk("prio_gap", 32'(t - tprev), 32'd40);
        repeat (2) @(negedge clk);
        chk("prio_idle", 32'(busy), 32'd0);

        // Overflow: 5 stream bytes fill FIFO + shifter, then a signal byte
        chk("ovf_before", 32'(overflow), 32'd0);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    bus.write_output = 1'b1;
                    bus.output_data = 8'(8'h21 + i);
                    @(negedge clk);
                end
                bus.write_output = 1'b0;
                #1;
                chk("ovf_full_stall", 32'(bus.stall), 32'd1);
                bus.start = 1'b1;
                bus.mode = TX_MODE_SIG;
                bus.sendsig = SIG_SEND_PROG;
                @(negedge clk);
                bus.start = 1'b0;
                bus.mode = TX_MODE_DMA;
                #1;
                chk("ovf_set", 32'(overflow), 32'd1);
                repeat (10) @(negedge clk);
                chk("ovf_sticky", 32'(overflow), 32'd1);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    rx_byte(b, t);
                    chk("ovf_byte", 32'(b), 32'(8'h21 + j));
                end
            end
        join
        @(negedge clk);
        chk("ovf_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ovf_no_extra", 32'(busy), 32'd0);
        chk("ovf_still", 32'(overflow), 32'd1);

        // Wrap-around trickle 0x10..0x18
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    bus.write_output = 1'b1;
                    bus.output_data = 8'(8'h10 + i);
                    @(negedge clk);
                    bus.write_output = 1'b0;
                    repeat (49) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 9; j++) begin
                    rx_byte(b, t);
                    chk("wrap_byte", 32'(b), 32'(8'h10 + j));
                end
            end
        join
        chk("wrap_idle", 32'(busy), 32'd0);

        // Reset during DATA bit 3 of 0x00 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            bus.write_output = 1'b1;
            bus.output_data = (i == 0) ? 8'h00 : 8'hFF;
            @(negedge clk);
        end
        bus.write_output = 1'b0;
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wait_bound", 32'(n < 100), 32'd1);
        repeat (17) @(negedge clk);
        chk("mid_bit3_low", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("mid_nothing_sent", 32'(lows), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
